// File: rtl/bcd_convert_ctrl_pkg.sv
// Shared types and sizing helpers for the iterative binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // The closed-form bound over-sizes some widths (21 for W=16); the decimal digit count of
  // 2^W-1 gives a tighter bound, so take whichever is smaller.
  function automatic int unsigned bcd_width(input int unsigned w);
    int unsigned loose;
    int unsigned digits;
    loose  = w + (w - 4) / 3 + 1;
    digits = ((w * 1233) >> 12) + 1;
    return (loose < 4 * digits) ? loose : 4 * digits;
  endfunction

  function automatic int unsigned bcd_digits(input int unsigned w);
    return (bcd_width(w) + 3) / 4;
  endfunction

endpackage

// File: rtl/bcd_convert_ctrl_if.sv
// Producer/consumer handshake bundle for bcd_convert_ctrl.
// The blank vector exists only when BCD_BLANK_EN is defined.
interface bcd_convert_ctrl_if
  import bcd_pkg::*;
#(
  parameter int unsigned W = 16
);
  localparam int unsigned BW = bcd_width(W);
  localparam int unsigned D  = bcd_digits(W);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  bin;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] bcd;
  logic          busy;
`ifdef BCD_BLANK_EN
  logic [D-1:0]  blank;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, busy, blank
  );
  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, busy, blank
  );
`else
  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, busy
  );
  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, busy
  );
`endif

endinterface

// File: rtl/bcd_dabble_digit.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_dabble_digit
  import bcd_pkg::*;
(
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  assign out_o = (in_i >= ADD3_THRESH) ? in_i + 4'd3 : in_i;

endmodule

// File: rtl/bcd_convert_ctrl.sv
// Iterative handshaked binary-to-BCD converter, one double-dabble step per clock.
// Optional BCD_BLANK_EN adds a registered leading-zero blanking vector.
module bcd_convert_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input logic               clk,
  input logic               rst_n,
  bcd_convert_ctrl_if.slave bus
);

  localparam int unsigned BW   = bcd_width(W);
  localparam int unsigned D    = bcd_digits(W);
  localparam int unsigned CntW = $clog2(W + 1);

  state_e            state_q, state_d;
  logic [W-1:0]      shreg_q, shreg_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     corr;
  logic [BW+W-1:0]   shifted;

  // A narrow top digit can never reach 5, so it is passed through uncorrected.
  for (genvar g = 0; g < D; g++) begin : g_digit
    localparam int unsigned Lo = 4 * g;
    if (Lo + 4 <= BW) begin : g_full
      bcd_dabble_digit u_digit (
        .in_i (scratch_q[Lo +: 4]),
        .out_o(corr[Lo +: 4])
      );
    end else begin : g_part
      assign corr[BW-1:Lo] = scratch_q[BW-1:Lo];
    end
  end

  assign shifted = {corr, shreg_q} << 1;

`ifdef BCD_BLANK_EN
  logic [D-1:0]   blank_q, blank_d;
  logic [D-1:0]   blank_calc;
  logic [4*D-1:0] padded;

  always_comb begin
    logic all_zero;
    padded   = (4 * D)'(shifted[BW+W-1:W]);
    all_zero = 1'b1;
    for (int i = D - 1; i >= 0; i--) begin
      all_zero      = all_zero & (padded[4*i +: 4] == 4'd0);
      blank_calc[i] = all_zero;
    end
    blank_calc[0] = 1'b0;
  end

  assign bus.blank = blank_q;
`endif

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
`ifdef BCD_BLANK_EN
    blank_d   = blank_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          shreg_d   = bus.bin;
          scratch_d = '0;
          cnt_d     = CntW'(W);
          state_d   = StShift;
        end
      end
      StShift: begin
        scratch_d = shifted[BW+W-1:W];
        shreg_d   = shifted[W-1:0];
        cnt_d     = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          bcd_d   = shifted[BW+W-1:W];
`ifdef BCD_BLANK_EN
          blank_d = blank_calc;
`endif
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
`ifdef BCD_BLANK_EN
      blank_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
`ifdef BCD_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StShift);
  assign bus.bcd       = bcd_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed self-checking bench for bcd_convert_ctrl at W=16 (BW=20, D=5).
module tb_bcd_convert_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bcd_convert_ctrl_if #(.W(16)) bus ();

  bcd_convert_ctrl #(.W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents v for one acceptance edge, then counts cycles until out_valid (bounded).
  task automatic start_and_wait(input logic [15:0] v, input logic rdy,
                                output int lat, output int busy_cnt);
    bus.bin       = v;
    bus.in_valid  = 1'b1;
    bus.out_ready = rdy;
    tick();
    bus.in_valid = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.bin       = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_checks++;
    if (bus.bcd !== 20'h00000) begin
      n_fail++; $display("FAIL reset_bcd: got %h want 00000", bus.bcd);
    end
`ifdef BCD_BLANK_EN
    n_checks++;
    if (bus.blank !== 5'b00000) begin
      n_fail++; $display("FAIL reset_blank: got %b want 00000", bus.blank);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    int lat, bc;
    start_and_wait(16'd0, 1'b1, lat, bc);
    n_checks++;
    if (lat !== 16) begin
      n_fail++; $display("FAIL zero_latency: got %0d want 16", lat);
    end
    n_checks++;
    if (bus.bcd !== 20'h00000) begin
      n_fail++; $display("FAIL zero_bcd: got %h want 00000", bus.bcd);
    end
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_handshake: got in_ready=%b out_valid=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_1234();
    int lat, bc;
    start_and_wait(16'd1234, 1'b1, lat, bc);
    n_checks++;
    if (bus.bcd !== 20'h01234) begin
      n_fail++; $display("FAIL d1234_bcd: got %h want 01234", bus.bcd);
    end
    n_checks++;
    if (bc !== 16) begin
      n_fail++; $display("FAIL d1234_busy_cycles: got %0d want 16", bc);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL d1234_busy_in_done: got %b want 0", bus.busy);
    end
    tick();
  endtask

  task automatic test_values();
    logic [15:0] vin [4] = '{16'd65535, 16'd10000, 16'd59, 16'd8080};
    logic [19:0] vexp[4] = '{20'h65535, 20'h10000, 20'h00059, 20'h08080};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      start_and_wait(vin[i], 1'b1, lat, bc);
      n_checks++;
      if (bus.bcd !== vexp[i] || lat !== 16) begin
        n_fail++;
        $display("FAIL value_%0d: got bcd=%h lat=%0d want bcd=%h lat=16",
                 vin[i], bus.bcd, lat, vexp[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat, bc;
    start_and_wait(16'd500, 1'b0, lat, bc);
    n_checks++;
    if (lat !== 16 || bus.bcd !== 20'h00500) begin
      n_fail++; $display("FAIL bp_result: got bcd=%h lat=%0d want 00500 16", bus.bcd, lat);
    end
    bus.bin      = 16'd77;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.bcd !== 20'h00500 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got out_valid=%b bcd=%h in_ready=%b want 1 00500 0",
                 i, bus.out_valid, bus.bcd, bus.in_ready);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.bcd !== 20'h00500) begin
      n_fail++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b bcd=%h want 0 1 00500",
               bus.out_valid, bus.in_ready, bus.bcd);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat, bc;
    bus.bin       = 16'd9999;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_still_busy: got %b want 1", bus.busy);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.bcd !== 20'h00000) begin
      n_fail++;
      $display("FAIL midrst_state: got in_ready=%b out_valid=%b busy=%b bcd=%h want 1 0 0 00000",
               bus.in_ready, bus.out_valid, bus.busy, bus.bcd);
    end
    rst_n = 1'b1;
    start_and_wait(16'd42, 1'b1, lat, bc);
    n_checks++;
    if (bus.bcd !== 20'h00042 || lat !== 16) begin
      n_fail++; $display("FAIL midrst_after_42: got bcd=%h lat=%0d want 00042 16", bus.bcd, lat);
    end
    tick();
  endtask

`ifdef BCD_BLANK_EN
  task automatic test_blank();
    logic [15:0] vin [4] = '{16'd7, 16'd0, 16'd10000, 16'd1234};
    logic [4:0]  vexp[4] = '{5'b11110, 5'b11110, 5'b00000, 5'b10000};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      start_and_wait(vin[i], 1'b1, lat, bc);
      n_checks++;
      if (bus.blank !== vexp[i]) begin
        n_fail++; $display("FAIL blank_%0d: got %b want %b", vin[i], bus.blank, vexp[i]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero();
    test_1234();
    test_values();
    test_backpressure();
    test_reset_mid_shift();
`ifdef BCD_BLANK_EN
    test_blank();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
